// File: rtl/switch_select_debounce.sv
// Two-channel push-button conditioner: synchronise, debounce, detect presses and
// step a wrapping select register up (switch 1) or down (switch 2).
module switch_select_debounce #(
  parameter int unsigned DEBOUNCE_LIMIT = 250000,
  parameter int unsigned SEL_BITS       = 2
) (
  input  logic                i_Clk,
  input  logic                i_Rst_L,
  input  logic                i_Switch_1,
  input  logic                i_Switch_2,
  output logic                o_Switch_1_Level,
  output logic                o_Switch_2_Level,
  output logic                o_Switch_1_Press,
  output logic                o_Switch_2_Press,
  output logic [SEL_BITS-1:0] o_Sel
);

  localparam int unsigned     CntW   = (DEBOUNCE_LIMIT > 1) ? $clog2(DEBOUNCE_LIMIT) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_LIMIT - 1);

  typedef enum logic [1:0] {
    StStableLow,
    StCountHigh,
    StStableHigh,
    StCountLow
  } db_state_e;

  logic [1:0]          raw;
  logic [1:0]          sync_meta_q;
  logic [1:0]          sync_q;
  logic [1:0]          level;
  logic [1:0]          level_prev_q;
  logic [1:0]          rise;
  logic [1:0]          press_q;
  logic [SEL_BITS-1:0] sel_q;

  assign raw = {i_Switch_2, i_Switch_1};

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      sync_meta_q <= '0;
      sync_q      <= '0;
    end else begin
      sync_meta_q <= raw;
      sync_q      <= sync_meta_q;
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_db
    db_state_e       state_q;
    logic [CntW-1:0] cnt_q;

    // cnt tracks how many consecutive edges s has disagreed with the stable level
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
        state_q <= StStableLow;
        cnt_q   <= '0;
      end else begin
        case (state_q)
          StStableLow: begin
            if (sync_q[g]) begin
              state_q <= StCountHigh;
              cnt_q   <= CntW'(1);
            end else begin
              cnt_q <= '0;
            end
          end
          StCountHigh: begin
            if (!sync_q[g]) begin
              state_q <= StStableLow;
              cnt_q   <= '0;
            end else if (cnt_q == CntMax) begin
              state_q <= StStableHigh;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + CntW'(1);
            end
          end
          StStableHigh: begin
            if (!sync_q[g]) begin
              state_q <= StCountLow;
              cnt_q   <= CntW'(1);
            end else begin
              cnt_q <= '0;
            end
          end
          StCountLow: begin
            if (sync_q[g]) begin
              state_q <= StStableHigh;
              cnt_q   <= '0;
            end else if (cnt_q == CntMax) begin
              state_q <= StStableLow;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + CntW'(1);
            end
          end
          default: begin
            state_q <= StStableLow;
            cnt_q   <= '0;
          end
        endcase
      end
    end

    assign level[g] = (state_q == StStableHigh) || (state_q == StCountLow);
  end

  assign rise = level & ~level_prev_q;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      level_prev_q <= '0;
      press_q      <= '0;
      sel_q        <= '0;
    end else begin
      level_prev_q <= level;
      press_q      <= rise;
      // Simultaneous presses cancel out
      case (rise)
        2'b01:   sel_q <= sel_q + SEL_BITS'(1);
        2'b10:   sel_q <= sel_q - SEL_BITS'(1);
        default: sel_q <= sel_q;
      endcase
    end
  end

  assign o_Switch_1_Level = level[0];
  assign o_Switch_2_Level = level[1];
  assign o_Switch_1_Press = press_q[0];
  assign o_Switch_2_Press = press_q[1];
  assign o_Sel            = sel_q;

endmodule

// File: tb/tb_switch_select_debounce.sv
// Directed bench for switch_select_debounce with DEBOUNCE_LIMIT=4, SEL_BITS=2.
module tb_switch_select_debounce;

  logic       clk;
  logic       rst_n;
  logic       sw1;
  logic       sw2;
  logic       lvl1;
  logic       lvl2;
  logic       prs1;
  logic       prs2;
  logic [1:0] sel;

  int n_checks = 0;
  int n_fail   = 0;
  int p1_cnt   = 0;
  int p2_cnt   = 0;
  int both_cnt = 0;
  int l1_seen  = 0;

  typedef struct packed {
    logic       sw1;
    logic       sw2;
    logic       rst;
    logic       l1;
    logic       l2;
    logic       p1;
    logic       p2;
    logic [1:0] sel;
  } vec_t;

  vec_t vecs[$];

  switch_select_debounce #(
    .DEBOUNCE_LIMIT(4),
    .SEL_BITS      (2)
  ) dut (
    .i_Clk           (clk),
    .i_Rst_L         (rst_n),
    .i_Switch_1      (sw1),
    .i_Switch_2      (sw2),
    .o_Switch_1_Level(lvl1),
    .o_Switch_2_Level(lvl2),
    .o_Switch_1_Press(prs1),
    .o_Switch_2_Press(prs2),
    .o_Sel           (sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive inputs, clock one edge, sample 1 time unit later.
  task automatic step(input logic s1, input logic s2, input logic r);
    sw1   = s1;
    sw2   = s2;
    rst_n = r;
    @(posedge clk);
    #1;
    if (prs1 === 1'b1) p1_cnt++;
    if (prs2 === 1'b1) p2_cnt++;
    if (prs1 === 1'b1 && prs2 === 1'b1) both_cnt++;
    if (lvl1 === 1'b1) l1_seen++;
  endtask

  task automatic hold(input logic s1, input logic s2, input int n);
    for (int i = 0; i < n; i++) step(s1, s2, 1'b1);
  endtask

  task automatic clr_counts();
    p1_cnt   = 0;
    p2_cnt   = 0;
    both_cnt = 0;
    l1_seen  = 0;
  endtask

  task automatic add(input logic s1, s2, r, l1, l2, p1, p2, input logic [1:0] sl);
    vec_t v;
    v = '{sw1: s1, sw2: s2, rst: r, l1: l1, l2: l2, p1: p1, p2: p2, sel: sl};
    vecs.push_back(v);
  endtask

  initial begin
    vec_t v;
    logic [5:0] act_bits;
    logic [5:0] exp_bits;

    rst_n = 1'b0;
    sw1   = 1'b0;
    sw2   = 1'b0;

    // Reset held with switches toggling, then a clean press and release of switch 1.
    add(1, 1, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) add(1, 0, 1, 0, 0, 0, 0, 0);
    add(1, 0, 1, 1, 0, 0, 0, 0);
    add(1, 0, 1, 1, 0, 1, 0, 1);
    add(1, 0, 1, 1, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) add(0, 0, 1, 1, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) add(0, 0, 1, 0, 0, 0, 0, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      step(v.sw1, v.sw2, v.rst);
      act_bits = {lvl1, lvl2, prs1, prs2, sel};
      exp_bits = {v.l1, v.l2, v.p1, v.p2, v.sel};
      check($sformatf("vec%0d {l1,l2,p1,p2,sel}", i), int'(act_bits), int'(exp_bits));
    end

    // Bounce rejection: 3 high, 1 low, 3 high never reaches the limit.
    clr_counts();
    hold(1, 0, 3);
    hold(0, 0, 1);
    hold(1, 0, 3);
    hold(0, 0, 8);
    check("bounce level1 cycles", l1_seen, 0);
    check("bounce press1", p1_cnt, 0);
    check("bounce sel", int'(sel), 1);
    clr_counts();
    hold(1, 0, 4);
    hold(0, 0, 10);
    check("4wide press1", p1_cnt, 1);
    check("4wide sel", int'(sel), 2);

    // Asynchronous reset mid-cycle clears sel before the next edge.
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("async rst sel", int'(sel), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Wrap upward, then one downward step from 0.
    for (int k = 1; k <= 4; k++) begin
      clr_counts();
      hold(1, 0, 8);
      hold(0, 0, 8);
      check($sformatf("wrap press1 #%0d", k), p1_cnt, 1);
      check($sformatf("wrap sel #%0d", k), int'(sel), k % 4);
    end
    clr_counts();
    hold(0, 1, 8);
    hold(0, 0, 8);
    check("down press2", p2_cnt, 1);
    check("down sel", int'(sel), 3);

    // Bring sel to 1, then press both together.
    hold(1, 0, 8);
    hold(0, 0, 8);
    hold(1, 0, 8);
    hold(0, 0, 8);
    check("pre-simul sel", int'(sel), 1);
    clr_counts();
    hold(1, 1, 10);
    check("simul press1", p1_cnt, 1);
    check("simul press2", p2_cnt, 1);
    check("simul same cycle", both_cnt, 1);
    check("simul sel", int'(sel), 1);
    clr_counts();
    hold(1, 1, 100);
    check("held press1", p1_cnt, 0);
    check("held press2", p2_cnt, 0);
    hold(0, 0, 10);

    // Reset mid-debounce on switch 2: count restarts after release.
    hold(0, 1, 4);
    step(0, 1, 1'b0);
    check("mid rst sel", int'(sel), 0);
    clr_counts();
    for (int k = 1; k <= 6; k++) begin
      step(0, 1, 1'b1);
      check($sformatf("mid rst level2 edge%0d", k), int'(lvl2), (k == 6) ? 1 : 0);
    end
    step(0, 1, 1'b1);
    check("mid rst press2 pulse", int'(prs2), 1);
    check("mid rst sel dec", int'(sel), 3);
    hold(0, 1, 20);
    check("mid rst press2 once", p2_cnt, 1);
    check("mid rst sel final", int'(sel), 3);
    hold(0, 0, 10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
